lane_skew_stager: RTL and testbench

LANE_SKEW_STAGER -- requirements
Module: lane_skew_stager

---
 rtl/lane_skew_stager_if.sv | 24 ++
 rtl/lane_skew_stager.sv | 92 +++++++++
 tb/tb_lane_skew_stager.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/lane_skew_stager_if.sv
// Bus bundle for lane_skew_stager: input beat, mode pins and the staged lane outputs.
// The producer side uses the master modport, the stager itself uses slave.
interface lane_skew_stager_if #(
  parameter int LENGTH     = 4,
  parameter int DATA_WIDTH = 16
);
  logic                         in_valid;
  logic [LENGTH*DATA_WIDTH-1:0] in_data;
  logic                         mode_reverse;
  logic                         mode_skew;
  logic [LENGTH*DATA_WIDTH-1:0] out_data;
  logic [LENGTH-1:0]            out_lane_valid;
  logic                         busy;

  modport master (
    output in_valid, in_data, mode_reverse, mode_skew,
    input  out_data, out_lane_valid, busy
  );

  modport slave (
    input  in_valid, in_data, mode_reverse, mode_skew,
    output out_data, out_lane_valid, busy
  );
endinterface

// File: rtl/lane_skew_stager.sv
// Lane permuter and systolic skew stager: each output lane k is a shift chain of depth 1+k.
// Mode is sampled from the pins while idle and held constant until every chain has drained.
module lane_skew_stager #(
  parameter int LENGTH     = 4,
  parameter int DATA_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  lane_skew_stager_if.slave bus
);

  logic [DATA_WIDTH-1:0] in_lane  [LENGTH];
  logic [DATA_WIDTH-1:0] out_lane [LENGTH];
  logic [LENGTH-1:0]     out_vld;
  logic [LENGTH-1:0]     lane_busy;

  logic rev_q, rev_d;
  logic skew_q, skew_d;
  logic busy_q, busy_d;
  logic rev_eff, skew_eff;

  always_comb begin
    for (int i = 0; i < LENGTH; i++) begin
      in_lane[i] = bus.in_data[DATA_WIDTH*i +: DATA_WIDTH];
    end
  end

  // Pins steer only an idle block; a drain in progress keeps the mode it started with.
  always_comb begin
    rev_eff  = busy_q ? rev_q  : bus.mode_reverse;
    skew_eff = busy_q ? skew_q : bus.mode_skew;
    rev_d    = rev_eff;
    skew_d   = skew_eff;
    busy_d   = |lane_busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rev_q  <= 1'b0;
      skew_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      rev_q  <= rev_d;
      skew_q <= skew_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < LENGTH; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] dat_d [k+1];
    logic [DATA_WIDTH-1:0] dat_q [k+1];
    logic [k:0]            vld_d;
    logic [k:0]            vld_q;

    // Stage 0 takes the permuted input; deeper stages only shift while skew is in effect.
    always_comb begin
      dat_d    = dat_q;
      vld_d    = vld_q;
      vld_d[0] = bus.in_valid;
      dat_d[0] = bus.in_valid ? (rev_eff ? in_lane[LENGTH-1-k] : in_lane[k]) : '0;
      for (int j = 1; j <= k; j++) begin
        vld_d[j] = skew_eff & vld_q[j-1];
        dat_d[j] = (skew_eff & vld_q[j-1]) ? dat_q[j-1] : '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        for (int j = 0; j <= k; j++) begin
          dat_q[j] <= '0;
        end
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign lane_busy[k] = |vld_d;
    assign out_vld[k]   = skew_eff ? vld_q[k] : vld_q[0];
    assign out_lane[k]  = skew_eff ? dat_q[k] : dat_q[0];
  end

  always_comb begin
    for (int i = 0; i < LENGTH; i++) begin
      bus.out_data[DATA_WIDTH*i +: DATA_WIDTH] = out_lane[i];
    end
    bus.out_lane_valid = out_vld;
    bus.busy           = busy_q;
  end

endmodule

// File: tb/tb_lane_skew_stager.sv
// Directed bench for lane_skew_stager at LENGTH=4, DATA_WIDTH=8 with hand-computed expectations.
module tb_lane_skew_stager;
  localparam int L  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  lane_skew_stager_if #(.LENGTH(L), .DATA_WIDTH(DW)) bus ();

  lane_skew_stager #(.LENGTH(L), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] d, input logic [3:0] v,
                            input logic b);
    check({tag, ".data"},  bus.out_data, d);
    check({tag, ".valid"}, {28'd0, bus.out_lane_valid}, {28'd0, v});
    check({tag, ".busy"},  {31'd0, bus.busy}, {31'd0, b});
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic s);
    bus.in_valid     = v;
    bus.in_data      = d;
    bus.mode_reverse = r;
    bus.mode_skew    = s;
  endtask

  initial begin
    // Reset, with a beat offered that must be ignored
    rst = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    tick();
    tick();
    expect_out("rst_hold", 32'h0, 4'b0000, 1'b0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    expect_out("post_rst", 32'h0, 4'b0000, 1'b0);

    // Reverse, no skew
    drive(1'b1, 32'h04030201, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("rev_t1", 32'h01020304, 4'b1111, 1'b1);
    tick();
    expect_out("rev_t2", 32'h0, 4'b0000, 1'b0);

    // Skew, no reverse
    drive(1'b1, 32'h04030201, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    expect_out("skew_t1", 32'h00000001, 4'b0001, 1'b1);
    tick();
    expect_out("skew_t2", 32'h00000200, 4'b0010, 1'b1);
    tick();
    expect_out("skew_t3", 32'h00030000, 4'b0100, 1'b1);
    tick();
    expect_out("skew_t4", 32'h04000000, 4'b1000, 1'b1);
    tick();
    expect_out("skew_t5", 32'h0, 4'b0000, 1'b0);

    // Three back-to-back skewed beats A, B, C
    drive(1'b1, 32'h13121110, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h23222120, 1'b0, 1'b1);
    expect_out("b2b_1", 32'h00000010, 4'b0001, 1'b1);
    tick();
    drive(1'b1, 32'h33323130, 1'b0, 1'b1);
    expect_out("b2b_2", 32'h00001120, 4'b0011, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    expect_out("b2b_3", 32'h00122130, 4'b0111, 1'b1);
    tick();
    expect_out("b2b_4", 32'h13223100, 4'b1110, 1'b1);
    tick();
    expect_out("b2b_5", 32'h23320000, 4'b1100, 1'b1);
    tick();
    expect_out("b2b_6", 32'h33000000, 4'b1000, 1'b1);
    tick();
    expect_out("b2b_7", 32'h0, 4'b0000, 1'b0);

    // Mode pins flipped mid-drain must not disturb the drain
    drive(1'b1, 32'h04030201, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("mchg_t1", 32'h00000001, 4'b0001, 1'b1);
    tick();
    expect_out("mchg_t2", 32'h00000200, 4'b0010, 1'b1);
    tick();
    expect_out("mchg_t3", 32'h00030000, 4'b0100, 1'b1);
    tick();
    expect_out("mchg_t4", 32'h04000000, 4'b1000, 1'b1);
    tick();
    expect_out("mchg_t5", 32'h0, 4'b0000, 1'b0);
    drive(1'b1, 32'h04030201, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("mchg_new", 32'h01020304, 4'b1111, 1'b1);
    tick();
    expect_out("mchg_idle", 32'h0, 4'b0000, 1'b0);

    // Reset in the middle of a skewed drain, with a beat offered during reset
    drive(1'b1, 32'h04030201, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    expect_out("mrst_t1", 32'h00000001, 4'b0001, 1'b1);
    tick();
    expect_out("mrst_t2", 32'h00000200, 4'b0010, 1'b1);
    rst = 1'b1;
    drive(1'b1, 32'hAABBCCDD, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    expect_out("mrst_t3", 32'h0, 4'b0000, 1'b0);
    tick();
    expect_out("mrst_t4", 32'h0, 4'b0000, 1'b0);
    tick();
    expect_out("mrst_t5", 32'h0, 4'b0000, 1'b0);

    // Bit patterns including a negative byte, unskewed reversed
    drive(1'b1, 32'hF8070605, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("neg_rev", 32'h050607F8, 4'b1111, 1'b1);
    tick();
    expect_out("neg_rev_idle", 32'h0, 4'b0000, 1'b0);

    // Same pattern skewed, unreversed
    drive(1'b1, 32'hF8070605, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    expect_out("neg_skw_t1", 32'h00000005, 4'b0001, 1'b1);
    tick();
    expect_out("neg_skw_t2", 32'h00000600, 4'b0010, 1'b1);
    tick();
    expect_out("neg_skw_t3", 32'h00070000, 4'b0100, 1'b1);
    tick();
    expect_out("neg_skw_t4", 32'hF8000000, 4'b1000, 1'b1);
    tick();
    expect_out("neg_skw_t5", 32'h0, 4'b0000, 1'b0);

    // Skewed and reversed together
    drive(1'b1, 32'hF8070605, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    expect_out("neg_both_t1", 32'h000000F8, 4'b0001, 1'b1);
    tick();
    expect_out("neg_both_t2", 32'h00000700, 4'b0010, 1'b1);
    tick();
    expect_out("neg_both_t3", 32'h00060000, 4'b0100, 1'b1);
    tick();
    expect_out("neg_both_t4", 32'h05000000, 4'b1000, 1'b1);
    tick();
    expect_out("neg_both_t5", 32'h0, 4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
